// File: rtl/epsilon_arbiter.sv
// epsilon_arbiter
//   Shares one epsilon datapath stage between requesters A and B. Samples are
//   accepted over valid/ready handshakes, at most one per cycle, alternating
//   round-robin. Each issue is tagged and the returning stage result is routed
//   to the originating requester. The block also owns the stage reset and keeps
//   the stage in reset long enough to drain in-flight data.
//
//   state | meaning
//   HOLD  | stage held in reset, drain counter running, no accepts
//   RUN   | stage live, requesters may be accepted
//
// Ports
//   clk, reset             clock, async active-low reset
//   a_valid/a_data/a_ready requester A handshake
//   b_valid/b_data/b_ready requester B handshake
//   d_out                  registered sample to the stage
//   e_in                   stage result
//   stage_reset            registered, active-high stage reset
//   ya_valid/ya_data       registered result for A (no backpressure)
//   yb_valid/yb_data       registered result for B (no backpressure)
module epsilon_arbiter #(
  parameter int WIDTH   = 20,
  parameter int LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  input  logic signed [WIDTH-1:0] a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic signed [WIDTH-1:0] b_data,
  output logic                    b_ready,
  output logic signed [WIDTH-1:0] d_out,
  input  logic signed [WIDTH-1:0] e_in,
  output logic                    stage_reset,
  output logic                    ya_valid,
  output logic signed [WIDTH-1:0] ya_data,
  output logic                    yb_valid,
  output logic signed [WIDTH-1:0] yb_data
);

  localparam int CW = $clog2(LATENCY + 2);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY + 1);

  typedef enum logic {HOLD, RUN} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_A, TAG_B} tag_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            ptr;              // 0: A has priority, 1: B has priority
  tag_t            tag_in;
  tag_t            pipe [LATENCY+1];
  logic            acc_a, acc_b;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    unique case (state)
      HOLD: begin
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - CW'(1);
      end
      RUN: begin
        // Ties resolve to the pointer; a lone requester always wins.
        a_ready = (ptr == 1'b0) | ~b_valid;
        b_ready = (ptr == 1'b1) | ~a_valid;
      end
      default: state_nxt = HOLD;
    endcase
  end

  assign acc_a = a_valid & a_ready;
  assign acc_b = b_valid & b_ready;

  always_comb begin
    tag_in = TAG_NONE;
    if (acc_a)      tag_in = TAG_A;
    else if (acc_b) tag_in = TAG_B;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HOLD;
      cnt         <= CNT_INIT;
      stage_reset <= 1'b1;
      ptr         <= 1'b0;
      d_out       <= '0;
      ya_valid    <= 1'b0;
      ya_data     <= '0;
      yb_valid    <= 1'b0;
      yb_data     <= '0;
      for (int i = 0; i <= LATENCY; i++) pipe[i] <= TAG_NONE;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      stage_reset <= (state_nxt == HOLD);
      if (acc_a) begin
        d_out <= a_data;
        ptr   <= 1'b1;
      end else if (acc_b) begin
        d_out <= b_data;
        ptr   <= 1'b0;
      end
      // Tag reaches the head on the edge the stage result is on e_in.
      pipe[0] <= tag_in;
      for (int i = 1; i <= LATENCY; i++) pipe[i] <= pipe[i-1];
      ya_valid <= (pipe[LATENCY] == TAG_A);
      yb_valid <= (pipe[LATENCY] == TAG_B);
      if (pipe[LATENCY] == TAG_A) ya_data <= e_in;
      if (pipe[LATENCY] == TAG_B) yb_data <= e_in;
    end
  end

endmodule

// File: tb/tb_epsilon_arbiter.sv
module tb_epsilon_arbiter;
  localparam int W = 20;
  localparam int L = 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                a_valid, b_valid;
  logic signed [W-1:0] a_data, b_data;
  logic                a_ready, b_ready;
  logic signed [W-1:0] d_out, e_in;
  logic                stage_reset;
  logic                ya_valid, yb_valid;
  logic signed [W-1:0] ya_data, yb_data;

  epsilon_arbiter #(.WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .d_out(d_out), .e_in(e_in), .stage_reset(stage_reset),
    .ya_valid(ya_valid), .ya_data(ya_data),
    .yb_valid(yb_valid), .yb_data(yb_data)
  );

  always #5 clk = ~clk;

  // Stage stub: pure delay line of LATENCY registers, cleared while in reset.
  logic signed [W-1:0] stg [L];
  always @(posedge clk) begin
    if (stage_reset) begin
      for (int i = 0; i < L; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d_out;
      for (int i = 1; i < L; i++) stg[i] <= stg[i-1];
    end
  end
  assign e_in = stg[L-1];

  typedef struct {
    int          tag;   // 1 = A, 2 = B
    logic [W-1:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   edges = 0;        // edges since reset release
  int   mptr = 0;         // 0: A next on a tie
  logic [W-1:0] mdout = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge reset)
    if (!reset) edges <= 0;
    else if (edges < 1000) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("valid_exclusive", {31'd0, ya_valid & yb_valid}, 32'd0);
      if (ya_valid || yb_valid) begin
        if (q.size() == 0) begin
          check("unexpected_result", {31'd0, ya_valid | yb_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          check("result_tag", ya_valid ? 32'd1 : 32'd2, e.tag);
          check("result_data", {12'd0, ya_valid ? ya_data : yb_data}, {12'd0, e.data});
          check("result_cycle", cyc, e.due);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check("result_missing", {31'd0, ya_valid | yb_valid}, 32'd1);
      end
    end
  end

  // One cycle of stimulus; called on a falling edge, returns on the next one.
  task automatic drive(input logic av, input logic [W-1:0] ad,
                       input logic bv, input logic [W-1:0] bd);
    bit run;
    int win;
    exp_t e;
    check("d_out", {12'd0, d_out}, {12'd0, mdout});
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    #1;
    run = reset && (edges >= L + 2);
    check("stage_reset", {31'd0, stage_reset}, {31'd0, !run});
    win = 0;
    if (run) begin
      if (av && (mptr == 0 || !bv)) win = 1;
      else if (bv) win = 2;
    end
    check("a_ready", {31'd0, a_ready & a_valid}, {31'd0, win == 1});
    check("b_ready", {31'd0, b_ready & b_valid}, {31'd0, win == 2});
    if (win != 0) begin
      e.tag  = win;
      e.data = (win == 1) ? ad : bd;
      e.due  = cyc + 1 + L + 1;
      q.push_back(e);
      mptr  = (win == 1) ? 1 : 0;
    end
    @(posedge clk);
    if (win != 0) mdout = e.data;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0);
  endtask

  // Asserts reset on a falling edge, checks asynchronous reset values, holds it.
  task automatic do_reset(input int n);
    reset = 1'b0;
    q.delete();
    mptr  = 0;
    mdout = '0;
    #1;
    check("rst_d_out", {12'd0, d_out}, 32'd0);
    check("rst_stage_reset", {31'd0, stage_reset}, 32'd1);
    check("rst_y_valid", {30'd0, ya_valid, yb_valid}, 32'd0);
    check("rst_y_data", {ya_data[15:0], yb_data[15:0]}, 32'd0);
    check("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
    @(negedge clk);
    for (int i = 1; i < n; i++) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    @(negedge clk);
    do_reset(2);
    idle(L + 3);

    // Single requester
    drive(1'b1, 20'd5, 1'b0, '0);
    drive(1'b1, 20'd6, 1'b0, '0);
    drive(1'b1, 20'd7, 1'b0, '0);
    idle(L + 3);

    // Contention
    for (int i = 0; i < 8; i++) drive(1'b1, 20'(100 + i), 1'b1, 20'(200 + i));
    idle(L + 3);

    // Routing with extreme values
    drive(1'b1, -20'sd3, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 20'sd524287);
    idle(L + 3);

    // Reset in flight
    drive(1'b1, 20'd100, 1'b0, '0);
    do_reset(2);
    idle(L + 3);
    drive(1'b1, 20'd101, 1'b0, '0);
    idle(L + 3);

    // Idle gap
    drive(1'b1, 20'd11, 1'b0, '0);
    idle(1);
    drive(1'b0, '0, 1'b1, 20'd22);
    drive(1'b1, 20'd33, 1'b0, '0);
    idle(L + 3);

    // Reset pulse during traffic, then randomized traffic with rare resets
    for (int i = 0; i < 3; i++) drive(1'b1, 20'(i), 1'b1, 20'(i + 9));
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 3));
      else drive(1'($urandom_range(0, 1)), 20'($urandom),
                 1'($urandom_range(0, 1)), 20'($urandom));
    end
    idle(L + 4);
    check("scoreboard_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got cycle %0d expected end", cyc);
    $fatal(1);
  end

endmodule

// File: doc/epsilon_arbiter.md
# epsilon_arbiter

Two-requester sequencer that time-shares one epsilon datapath stage (20-bit signed sample in on `D_out`, result out on `E_out`). It accepts samples from requesters A and B over valid/ready handshakes and issues at most one sample per cycle to the stage, alternating round-robin. It tags every issue and routes each returned result to the originating requester's output. It also owns the stage's active-high reset and holds the stage in reset long enough to drain in-flight data.

## Interface
- `WIDTH`, 20: sample width, two's complement signed.
- `LATENCY`, 1: edges from the stage sampling `D_out` to `E_out` showing the result. Legal range is 1..8.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  requester A has a sample.
- `a_data`  in  WIDTH  requester A sample, signed.
- `a_ready`  out  1  A is accepted on this edge when `a_valid` is high.
- `b_valid`, `b_data`, `b_ready`: same as the A signals, for requester B.
- `d_out`  out  WIDTH  registered; drives the stage `D_out`.
- `e_in`  in  WIDTH  from the stage `E_out`.
- `stage_reset`  out  1  registered; drives the stage `reset`, active-high.
- `ya_valid`, `ya_data`  out  1, WIDTH  registered result for A.
- `yb_valid`, `yb_data`  out  1, WIDTH  registered result for B.

## Operation
- **FSM states.** There are two states, HOLD and RUN.
  - While `reset` is low, the FSM is forced to HOLD and the drain counter is loaded with LATENCY+1.
  - In HOLD, the counter decrements once per edge. The FSM moves HOLD→RUN on the edge where the counter is 0.
  - There is no other way into HOLD.
- **Reset values.**
  - `d_out`=0, `stage_reset`=1, `ya_valid`=`yb_valid`=0, `ya_data`=`yb_data`=0.
  - Priority pointer = A, tag pipe = all NONE.
- **stage_reset.** Registered; it is 1 in HOLD and 0 in RUN.
- **Ready rules.**
  - Both `a_ready` and `b_ready` are 0 outside RUN.
  - In RUN:
    - `a_ready` = (ptr==A) | !`b_valid`.
    - `b_ready` = (ptr==B) | !`a_valid`.
  - Both ready signals are combinational from the valids and ptr.
  - At most one accept per edge; `a_ready & a_valid & b_ready & b_valid` is never true.
- **Accept.**
  - On accept, `d_out` loads the winner's data unchanged (sign preserved, no width change).
  - ptr moves to the other requester.
  - Tag A or B enters the tag pipe.
- **No accept.** `d_out` holds its value, ptr is unchanged, and tag NONE enters the pipe.
- **Tag pipe.** A shift register LATENCY+1 deep.
  - At the head, tag A sets `ya_valid`=1 and `ya_data`=`e_in`.
  - Tag B does the same on `yb_valid`/`yb_data`.
  - Tag NONE deasserts both valids.
  - `y*_data` holds its value while the matching valid is 0.
- **Backpressure.** Result outputs have none; requesters must consume them in the valid cycle.
- **Reset mid-operation.** Every in-flight tag is cleared to NONE, so no result of a pre-reset sample ever appears. The stage is reset concurrently via `stage_reset`.

## Timing
- **Accept to d_out.** Accept on edge k; `d_out` shows the sample after edge k.
- **Stage output.** The stage presents the result on `e_in` after edge k+LATENCY.
- **Result out.** `y*_valid`/`y*_data` are high after edge k+LATENCY+1, for exactly one cycle per sample.
- **Total latency.** Handshake to result is LATENCY+1 cycles.
- **Throughput.** One sample per cycle total.
- **Continuous contention.** With both valids held high, grants go A,B,A,B,…, with A first after reset.
- **Release from reset.**
  - After `reset` deasserts, `stage_reset` stays 1 for LATENCY+2 edges. The count is LATENCY+1 down to 0, with the HOLD→RUN transition on the count-0 edge.
  - The first possible accept is on the following edge.
  - With LATENCY=1: `stage_reset` falls after the 3rd edge, and ready can first be high before the 4th edge.

## Test plan
- **Reset release.** Pulse `reset` low during traffic, then release (LATENCY=1).
  - All outputs go to their reset values immediately (asynchronously).
  - `stage_reset`=1 and ready=0 for 3 edges, then `stage_reset`=0 and ready=1.
- **Single requester.** Only A valid, with data 5, 6, 7 on consecutive cycles.
  - `d_out` = 5, 6, 7 on consecutive cycles.
  - `ya_valid` is high for 3 consecutive cycles, starting 2 cycles after the first accept.
  - `yb_valid` stays 0.
- **Contention.** Both valid for 8 cycles.
  - Grant order is A,B,A,B,A,B,A,B.
  - The ready signals are never both high while both valids are high.
- **Routing, LATENCY=1.** The stage is a stub that registers `d_out`. Drive A=-3, then B=524287.
  - `ya_data`=-3 two cycles after its accept.
  - `yb_data`=524287 one cycle later.
  - The valids are mutually exclusive.
- **Reset in flight.** Accept A=100, then assert `reset` on the next cycle.
  - `ya_valid` never rises for 100.
  - After release, the next sample returns normally.
- **Idle gap.** A valid, idle, B valid, A valid.
  - The idle cycle issues nothing and returns no result.
  - ptr is unchanged across the gap.
  - Order is A,B,A, with results spaced to match.
